pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Generic parametrised pipeline stage register that replaces the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) in the pipelined RV32 core.
- Carries a data bundle and a control bundle, with a valid/ready handshake.
- A 2-entry skid buffer lets back-pressure (stall) be absorbed without a combinational ready path.
- Synchronous flush injects a bubble (control zeroed, valid dropped) for branch/jump redirect.

Parameters:
DATA_W, 160, width of data bundle (e.g. RD1, RD2, ImmExt, PC, PCPlus4 concatenated)
CTRL_W, 13, width of control bundle (RegWrite, MemWrite, Jump, Branch, ALUSrc, ResultSrc, ImmSrc, ALUControl, ...)
CNT_W, 32, width of the stall counter (optional feature only)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  upstream stage holds a valid instruction
in_ready  out  1  stage can accept; registered, no combinational path from out_ready
in_data  in  DATA_W  upstream data bundle
in_ctrl  in  CTRL_W  upstream control bundle
flush  in  1  synchronous bubble request (branch taken / jump)
out_valid  out  1  out_data/out_ctrl hold a valid instruction
out_ready  in  1  downstream stage accepts this cycle
out_data  out  DATA_W  data bundle to next stage
out_ctrl  out  CTRL_W  control bundle to next stage; all-zero whenever out_valid=0
stall_cycles  out  CNT_W  count of back-pressured cycles (see Optional Feature)

Behaviour:
- Storage: main entry (drives outputs) plus skid entry. Each entry holds data, ctrl and a valid bit.
- States, encoded by the valid bits:
  - EMPTY: main=0, skid=0
  - ONE: main=1, skid=0
  - FULL: main=1, skid=1
- in_ready = ~skid_valid, registered. It is 1 in EMPTY and ONE, and 0 in FULL.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- Transitions when flush=0:
  - EMPTY + accept -> ONE. Main loads input; latency 1 cycle from accept to out_valid.
  - ONE + accept + drain -> ONE. Main reloads with the new input.
  - ONE + accept + no drain -> FULL. Input goes to skid; main holds.
  - ONE + drain + no accept -> EMPTY.
  - FULL + drain -> ONE. Skid moves to main; no accept is possible in FULL.
  - No accept and no drain: hold state and contents.
- Ordering is strictly FIFO; no instruction is duplicated or dropped except by flush.
- Flush (priority over accept and drain):
  - Next edge: both valid bits cleared, both ctrl fields cleared to 0, state EMPTY.
  - Any input offered in the flush cycle is discarded, even if in_ready=1.
  - Data fields hold their value (don't-care).
  - in_ready=1 on the following cycle.
- out_ctrl is gated to zero when out_valid=0, so a bubble can never assert RegWrite or MemWrite.
- Reset (asynchronous, active-high):
  - All valid bits 0, all data and ctrl registers 0.
  - out_valid=0, out_data=0, out_ctrl=0, in_ready=1, stall_cycles=0.
  - Reset asserted mid-transfer abandons both entries immediately, without waiting for a clock edge.
- out_data/out_ctrl must stay stable while out_valid=1 and out_ready=0.

Optional Feature:
Macro PIPE_STAGE_PERF_EN.
- Defined: stall_cycles increments by 1 on each clock where out_valid=1 and out_ready=0.
  - Saturates at all-ones and does not wrap.
  - Cleared only by rst; flush does not clear it.
- Undefined: the counter register is not built and stall_cycles is tied to 0. The port list is unchanged.

Test Plan:
- Reset then stream: rst 1->0; present in_data=0x...A5, in_ctrl=0x1FFF with out_ready=1 held high -> out_valid=1 exactly one cycle later with the same values; in_ready stays 1; one result per cycle over 8 back-to-back inputs, in order.
- Back-pressure: out_ready=0 while sending 3 inputs D0,D1,D2 -> D0 in main, D1 in skid, in_ready=0 after D1; D2 held upstream. Raise out_ready -> outputs D0,D1,D2 on consecutive cycles; no loss or duplication.
- Flush in FULL: stage holding D0,D1 plus flush=1 with in_valid=1 (D2) -> next cycle out_valid=0, out_ctrl=0, in_ready=1; D2 never appears at the output.
- Async reset mid-operation: in FULL state, pulse rst between clock edges -> out_valid=0 and in_ready=1 immediately, before the next edge.
- Bubble safety: in_valid=0 for 5 cycles with in_ctrl=0x1FFF driven -> out_ctrl=0 throughout.
- PIPE_STAGE_PERF_EN: hold out_valid=1 with out_ready=0 for 10 cycles -> stall_cycles=10. With CNT_W=4 and 20 stall cycles -> stall_cycles=15 (saturated). Macro undefined -> stall_cycles stays 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- generic pipeline stage register with a 2-entry skid buffer.
//
// Sits between two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and carries
// a data bundle and a control bundle under a valid/ready handshake. The skid
// entry absorbs one extra instruction when the downstream stage stalls, so
// in_ready is a pure flop output with no combinational path from out_ready.
// A synchronous flush turns the stage into a bubble for branch/jump redirect.
//
// Optional feature: define PIPE_STAGE_PERF_EN to build a saturating counter of
// back-pressured cycles on stall_cycles. Without it stall_cycles is tied to 0.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   in_valid     upstream holds a valid instruction
//   in_ready     stage can accept (registered)
//   in_data      upstream data bundle  [DATA_W]
//   in_ctrl      upstream control bundle [CTRL_W]
//   flush        synchronous bubble request
//   out_valid    out_data/out_ctrl hold a valid instruction
//   out_ready    downstream accepts this cycle
//   out_data     data bundle to next stage [DATA_W]
//   out_ctrl     control bundle to next stage, zero when out_valid=0 [CTRL_W]
//   stall_cycles back-pressured cycle count [CNT_W]
//
// state | meaning
// ------+---------------------------------------------------
// EMPTY | no instruction held; main and skid invalid
// ONE   | main holds the instruction shown at the outputs
// FULL  | main shown at outputs, skid holds the next one

module pipe_stage_reg #(
  parameter int DATA_W = 160,
  parameter int CTRL_W = 13,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cycles
);

  // The state encoding is the pair of entry valid bits {skid, main}, so the
  // state register doubles as the valid flags of the two entries.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              main_valid, skid_valid;

  logic accept, drain;
  logic load_main_in, load_main_skid, load_skid_in, clear_ctrl;

  assign main_valid = state_q[0];
  assign skid_valid = state_q[1];

  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign drain    = main_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    clear_ctrl     = 1'b0;
    if (flush) begin
      // Flush wins over accept and drain: whatever is offered is dropped.
      state_d    = EMPTY;
      clear_ctrl = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d      = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && drain) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_d      = FULL;
            load_skid_in = 1'b1;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the skid-to-main move can happen.
          if (drain) begin
            state_d        = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      if (load_main_in) begin
        main_data <= in_data;
        main_ctrl <= in_ctrl;
      end else if (load_main_skid) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end
      if (load_skid_in) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
      end
      // Data fields are left alone on flush; only control must not leak.
      if (clear_ctrl) begin
        main_ctrl <= '0;
        skid_ctrl <= '0;
      end
    end
  end

  assign out_valid = main_valid;
  assign out_data  = main_data;
  // A bubble must never assert RegWrite/MemWrite downstream.
  assign out_ctrl  = main_valid ? main_ctrl : '0;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (main_valid && !out_ready && !(&stall_q)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
  localparam int DATA_W = 160;
  localparam int CTRL_W = 13;
  localparam int CNT_W  = 32;
`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]  stall_cycles;

  logic              in_ready2;
  logic              out_valid2;
  logic [DATA_W-1:0] out_data2;
  logic [CTRL_W-1:0] out_ctrl2;
  logic [3:0]        stall4;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ctrl(out_ctrl), .stall_cycles(stall_cycles)
  );

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_ctrl(out_ctrl2), .stall_cycles(stall4)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a 2-deep FIFO of {data, ctrl} plus saturating counters.
  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
  } ent_t;

  ent_t             mq[$];
  logic [CNT_W-1:0] m_stall;
  logic [3:0]       m_stall4;

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] r;
    r = '0;
    repeat ((DATA_W + 31) / 32) r = (r << 32) | DATA_W'($urandom);
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] exp_stall();
    return PERF ? m_stall : '0;
  endfunction

  function automatic logic [3:0] exp_stall4();
    return PERF ? m_stall4 : 4'h0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_stall  = '0;
    m_stall4 = '0;
  endtask

  // Advance one clock; the model consumes the inputs seen at the edge.
  task automatic tick();
    int   sz;
    ent_t e;
    @(posedge clk);
    sz = mq.size();
    if (sz > 0 && !out_ready) begin
      if (m_stall != '1) m_stall = m_stall + 1'b1;
      if (m_stall4 != 4'hF) m_stall4 = m_stall4 + 1'b1;
    end
    if (flush) begin
      mq.delete();
    end else begin
      if (sz > 0 && out_ready) void'(mq.pop_front());
      if (in_valid && sz < 2) begin
        e.d = in_data;
        e.c = in_ctrl;
        mq.push_back(e);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_data = '0; in_ctrl = '0;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    checks++; if (out_ctrl !== '0) begin errors++; $display("FAIL reset_out_ctrl: got %h want 0", out_ctrl); end
    checks++; if (stall_cycles !== '0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall_cycles); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_stream();
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
    out_ready = 1'b1; in_valid = 1'b1; flush = 1'b0;
    d = rand_data(); d[7:0] = 8'hA5; c = 13'h1FFF;
    in_data = d; in_ctrl = c;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_first_valid: got %b want 1", out_valid); end
    checks++; if (out_data !== d) begin errors++; $display("FAIL stream_first_data: got %h want %h", out_data, d); end
    checks++; if (out_ctrl !== c) begin errors++; $display("FAIL stream_first_ctrl: got %h want %h", out_ctrl, c); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_first_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 8; i++) begin
      d = rand_data(); c = CTRL_W'($urandom);
      in_data = d; in_ctrl = c;
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== d || out_ctrl !== c) begin
        errors++; $display("FAIL stream_item%0d: got v=%b %h/%h want v=1 %h/%h", i, out_valid, out_data, out_ctrl, d, c);
      end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready%0d: got %b want 1", i, in_ready); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] d0, d1, d2;
    d0 = rand_data(); d1 = rand_data(); d2 = rand_data();
    out_ready = 1'b0; in_valid = 1'b1; flush = 1'b0; in_ctrl = 13'h0A5;
    in_data = d0; tick();
    checks++; if (out_data !== d0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_d0: got %h rdy=%b want %h rdy=1", out_data, in_ready, d0); end
    in_data = d1; tick();
    checks++; if (out_data !== d0 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_d1_skid: got %h rdy=%b want %h rdy=0", out_data, in_ready, d0); end
    in_data = d2; tick();
    checks++; if (out_valid !== 1'b1 || out_data !== d0 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold: got v=%b %h rdy=%b want v=1 %h rdy=0", out_valid, out_data, in_ready, d0); end
    out_ready = 1'b1; tick();
    checks++; if (out_data !== d1 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_out_d1: got %h rdy=%b want %h rdy=1", out_data, in_ready, d1); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== d2) begin errors++; $display("FAIL bp_out_d2: got v=%b %h want v=1 %h", out_valid, out_data, d2); end
    in_valid = 1'b0; tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; flush = 1'b0; in_ctrl = 13'h1FFF;
    in_data = rand_data(); tick();
    in_data = rand_data(); tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_full_ready: got %b want 0", in_ready); end
    flush = 1'b1; in_data = rand_data(); tick();
    checks++; if (out_valid !== 1'b0 || out_ctrl !== '0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_bubble: got v=%b ctrl=%h rdy=%b want v=0 ctrl=0 rdy=1", out_valid, out_ctrl, in_ready);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) begin
      tick();
      checks++; if (out_valid !== 1'b0 || out_ctrl !== '0) begin errors++; $display("FAIL flush_no_d2: got v=%b ctrl=%h want v=0 ctrl=0", out_valid, out_ctrl); end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; flush = 1'b0; in_ctrl = 13'h1FFF;
    in_data = rand_data(); tick();
    in_data = rand_data(); tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL arst_full: got %b want 0", in_ready); end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL arst_immediate: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
    checks++; if (out_data !== '0 || out_ctrl !== '0) begin errors++; $display("FAIL arst_regs: got %h/%h want 0/0", out_data, out_ctrl); end
    checks++; if (stall_cycles !== '0 || stall4 !== 4'h0) begin errors++; $display("FAIL arst_stall: got %0d/%0d want 0/0", stall_cycles, stall4); end
    model_reset();
    #1 rst = 1'b0;
  endtask

  task automatic test_bubble();
    in_valid = 1'b0; in_ctrl = 13'h1FFF; out_ready = 1'b1; flush = 1'b0;
    repeat (5) begin
      in_data = rand_data();
      tick();
      checks++; if (out_ctrl !== '0 || out_valid !== 1'b0) begin errors++; $display("FAIL bubble_ctrl: got v=%b ctrl=%h want v=0 ctrl=0", out_valid, out_ctrl); end
    end
  endtask

  task automatic test_perf();
    logic [DATA_W-1:0] d;
    @(negedge clk); rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    d = rand_data();
    in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0; in_data = d; in_ctrl = 13'h0F0;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    checks++; if (stall_cycles !== (PERF ? CNT_W'(10) : '0)) begin errors++; $display("FAIL perf_10: got %0d want %0d", stall_cycles, PERF ? 10 : 0); end
    repeat (10) tick();
    checks++; if (stall_cycles !== (PERF ? CNT_W'(20) : '0)) begin errors++; $display("FAIL perf_20: got %0d want %0d", stall_cycles, PERF ? 20 : 0); end
    checks++; if (stall4 !== (PERF ? 4'hF : 4'h0)) begin errors++; $display("FAIL perf_sat: got %0d want %0d", stall4, PERF ? 15 : 0); end
    checks++; if (out_valid !== 1'b1 || out_data !== d || out_ctrl !== 13'h0F0) begin errors++; $display("FAIL perf_stable: got v=%b %h/%h want v=1 %h/0f0", out_valid, out_data, out_ctrl, d); end
  endtask

  task automatic test_random();
    logic              ev;
    logic [CTRL_W-1:0] ec;
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = 1'($urandom_range(0, 15) == 0);
      in_data   = rand_data();
      in_ctrl   = CTRL_W'($urandom);
      tick();
      ev = (mq.size() > 0);
      ec = ev ? mq[0].c : '0;
      checks++; if (out_valid !== ev || in_ready !== (mq.size() < 2)) begin
        errors++; $display("FAIL rand_hs%0d: got v=%b rdy=%b want v=%b rdy=%b", i, out_valid, in_ready, ev, mq.size() < 2);
      end
      checks++; if (out_ctrl !== ec) begin errors++; $display("FAIL rand_ctrl%0d: got %h want %h", i, out_ctrl, ec); end
      if (ev) begin
        checks++; if (out_data !== mq[0].d) begin errors++; $display("FAIL rand_data%0d: got %h want %h", i, out_data, mq[0].d); end
      end
      checks++; if (stall_cycles !== exp_stall() || stall4 !== exp_stall4()) begin
        errors++; $display("FAIL rand_stall%0d: got %0d/%0d want %0d/%0d", i, stall_cycles, stall4, exp_stall(), exp_stall4());
      end
      checks++; if (out_valid2 !== ev || in_ready2 !== (mq.size() < 2) || out_ctrl2 !== ec || (ev && out_data2 !== mq[0].d)) begin
        errors++; $display("FAIL rand_sat_inst%0d: got v=%b rdy=%b ctrl=%h want v=%b ctrl=%h", i, out_valid2, in_ready2, out_ctrl2, ev, ec);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_bubble();
    test_perf();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
